adat_frame_sequencer: RTL and testbench

- Consumes the recovered NRZI bitstream (one bit per `bit_valid` strobe) from the ADAT input decoder.
- Hunts for ADAT frame sync, tracks the 256-bit frame position and checks the separator bits.
- Delivers 8 channels of 24-bit samples plus 4 user bits per frame, and maintains a lock flag.
- Sits between the NRZI decoder and the channel/sample-rate logic of the ADAT receiver.

---
 rtl/adat_frame_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_adat_frame_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adat_frame_sequencer.sv
// ADAT frame sequencer: hunts for frame sync, walks the 256-bit frame, checks
// the separator bits and delivers 8 x 24-bit samples plus 4 user bits per frame.
module adat_frame_sequencer #(
  parameter int unsigned TIMEOUT     = 32,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        refclk,
  input  logic        reset_n,
  input  logic        bit_valid,
  input  logic        din,
  output logic [23:0] sample,
  output logic [2:0]  channel,
  output logic        sample_valid,
  output logic [3:0]  user,
  output logic        user_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StHunt, StData, StSyncChk} state_e;

  state_e         state_q, state_d;
  logic [3:0]     zcnt_q, zcnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [5:0]     grp_q, grp_d;
  logic [2:0]     nib_q, nib_d;     // nibble index within the current channel
  logic [2:0]     chan_q, chan_d;   // channel currently being assembled
  logic [23:0]    shift_q, shift_d;
  logic [3:0]     ushift_q, ushift_d;
  logic [2:0]     good_q, good_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [23:0]    sample_q, sample_d;
  logic [2:0]     channel_q, channel_d;
  logic [3:0]     user_q, user_d;
  logic           locked_q, locked_d;
  logic           sv_q, sv_d;
  logic           uv_q, uv_d;
  logic           fs_q, fs_d;
  logic           err_q, err_d;
  logic           timeout;
  logic [2:0]     good_inc;

  assign good_inc = (good_q < 3'(LOCK_FRAMES)) ? good_q + 3'd1 : good_q;
  // Fires on the cycle the idle counter would reach TIMEOUT.
  assign timeout  = !bit_valid && (wd_q == WdW'(TIMEOUT - 1));

  // Next-state logic: watchdog, sync hunt, data walk and sync check.
  always_comb begin
    state_d   = state_q;
    zcnt_d    = zcnt_q;
    bit_d     = bit_q;
    grp_d     = grp_q;
    nib_d     = nib_q;
    chan_d    = chan_q;
    shift_d   = shift_q;
    ushift_d  = ushift_q;
    good_d    = good_q;
    sample_d  = sample_q;
    channel_d = channel_q;
    user_d    = user_q;
    locked_d  = locked_q;
    sv_d      = 1'b0;
    uv_d      = 1'b0;
    fs_d      = 1'b0;
    err_d     = 1'b0;

    if (bit_valid) begin
      wd_d = '0;
    end else if (wd_q != WdW'(TIMEOUT)) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end

    if (timeout) begin
      zcnt_d = 4'd0;
      if (state_q != StHunt) begin
        err_d    = 1'b1;
        locked_d = 1'b0;
        good_d   = 3'd0;
        state_d  = StHunt;
      end
    end else if (bit_valid) begin
      case (state_q)
        StHunt: begin
          if (din) begin
            zcnt_d = 4'd0;
            if (zcnt_q >= 4'd10) begin
              state_d = StData;
              fs_d    = 1'b1;
              bit_d   = 3'd0;
              grp_d   = 6'd0;
              nib_d   = 3'd0;
              chan_d  = 3'd0;
            end
          end else if (zcnt_q != 4'd15) begin
            zcnt_d = zcnt_q + 4'd1;
          end
        end
        StData: begin
          if (bit_q != 3'd4) begin
            if (grp_q == 6'd0) ushift_d = {ushift_q[2:0], din};
            else               shift_d  = {shift_q[22:0], din};
            bit_d = bit_q + 3'd1;
          end else if (!din) begin
            // Broken separator; this zero already counts toward the next sync.
            err_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = 3'd0;
            state_d  = StHunt;
            zcnt_d   = 4'd1;
          end else begin
            bit_d = 3'd0;
            grp_d = grp_q + 6'd1;
            if (grp_q == 6'd0) begin
              user_d = ushift_q;
              uv_d   = locked_q;
            end else if (nib_q == 3'd5) begin
              sample_d  = shift_q;
              channel_d = chan_q;
              sv_d      = locked_q;
              nib_d     = 3'd0;
              chan_d    = chan_q + 3'd1;
            end else begin
              nib_d = nib_q + 3'd1;
            end
            if (grp_q == 6'd48) begin
              state_d = StSyncChk;
              zcnt_d  = 4'd0;
            end
          end
        end
        StSyncChk: begin
          if (!din) begin
            if (zcnt_q == 4'd10) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              good_d   = 3'd0;
              state_d  = StHunt;
              zcnt_d   = 4'd1;
            end else begin
              zcnt_d = zcnt_q + 4'd1;
            end
          end else if (zcnt_q == 4'd10) begin
            good_d = good_inc;
            if (good_inc == 3'(LOCK_FRAMES)) locked_d = 1'b1;
            fs_d    = 1'b1;
            state_d = StData;
            zcnt_d  = 4'd0;
            bit_d   = 3'd0;
            grp_d   = 6'd0;
            nib_d   = 3'd0;
            chan_d  = 3'd0;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = 3'd0;
            state_d  = StHunt;
            zcnt_d   = 4'd0;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StHunt;
      zcnt_q    <= '0;
      bit_q     <= '0;
      grp_q     <= '0;
      nib_q     <= '0;
      chan_q    <= '0;
      shift_q   <= '0;
      ushift_q  <= '0;
      good_q    <= '0;
      wd_q      <= '0;
      sample_q  <= '0;
      channel_q <= '0;
      user_q    <= '0;
      locked_q  <= 1'b0;
      sv_q      <= 1'b0;
      uv_q      <= 1'b0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      zcnt_q    <= zcnt_d;
      bit_q     <= bit_d;
      grp_q     <= grp_d;
      nib_q     <= nib_d;
      chan_q    <= chan_d;
      shift_q   <= shift_d;
      ushift_q  <= ushift_d;
      good_q    <= good_d;
      wd_q      <= wd_d;
      sample_q  <= sample_d;
      channel_q <= channel_d;
      user_q    <= user_d;
      locked_q  <= locked_d;
      sv_q      <= sv_d;
      uv_q      <= uv_d;
      fs_q      <= fs_d;
      err_q     <= err_d;
    end
  end

  assign sample       = sample_q;
  assign channel      = channel_q;
  assign sample_valid = sv_q;
  assign user         = user_q;
  assign user_valid   = uv_q;
  assign frame_start  = fs_q;
  assign locked       = locked_q;
  assign sync_err     = err_q;

endmodule

// File: tb/tb_adat_frame_sequencer.sv
// Directed bench for adat_frame_sequencer: a table of whole frames plus
// hand-written watchdog and mid-frame reset sequences.
module tb_adat_frame_sequencer;

  localparam int TO = 32;
  localparam int LF = 2;

  logic        refclk = 1'b0;
  logic        reset_n;
  logic        bit_valid;
  logic        din;
  logic [23:0] sample;
  logic [2:0]  channel;
  logic        sample_valid;
  logic [3:0]  user;
  logic        user_valid;
  logic        frame_start;
  logic        locked;
  logic        sync_err;

  adat_frame_sequencer #(.TIMEOUT(TO), .LOCK_FRAMES(LF)) dut (
    .refclk      (refclk),
    .reset_n     (reset_n),
    .bit_valid   (bit_valid),
    .din         (din),
    .sample      (sample),
    .channel     (channel),
    .sample_valid(sample_valid),
    .user        (user),
    .user_valid  (user_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 refclk = ~refclk;

  int total = 0;
  int bad   = 0;

  // Pulse monitor, sampled on the inactive edge.
  int          n_fs = 0, n_err = 0, n_uv = 0, n_coinc = 0;
  logic [3:0]  last_user = '0;
  logic [2:0]  q_ch[$];
  logic [23:0] q_smp[$];
  logic        fs_now;

  always @(negedge refclk) begin
    if (frame_start) n_fs++;
    if (sync_err) n_err++;
    if (user_valid) begin
      n_uv++;
      last_user = user;
    end
    if (sample_valid) begin
      q_ch.push_back(channel);
      q_smp.push_back(sample);
    end
    if (sync_err && (frame_start || sample_valid || user_valid)) n_coinc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] chval(input logic [23:0] base, input int n);
    return base + 24'(n) * 24'h100000;
  endfunction

  // One bit every 8 refclk; fs_now is frame_start one cycle after the strobe.
  task automatic send_bit(input logic b);
    @(posedge refclk); #1;
    bit_valid = 1'b1;
    din       = b;
    @(posedge refclk); #1;
    bit_valid = 1'b0;
    fs_now    = frame_start;
    repeat (6) @(posedge refclk);
  endtask

  task automatic send_sync(input int nz);
    for (int i = 0; i < nz; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic send_groups(input int g0, input int g1, input int badg,
                             input logic [23:0] base, input logic [3:0] usr);
    logic [23:0] d;
    logic [3:0]  nib;
    for (int g = g0; g <= g1; g++) begin
      if (g == 0) begin
        nib = usr;
      end else begin
        d   = chval(base, (g - 1) / 6);
        nib = d[23 - 4 * ((g - 1) % 6) -: 4];
      end
      for (int b = 3; b >= 0; b--) send_bit(nib[b]);
      send_bit(g == badg ? 1'b0 : 1'b1);
    end
  endtask

  typedef struct {
    int          nz;
    int          badg;
    logic [23:0] base;
    logic [3:0]  usr;
    int          e_fs;
    int          e_err;
    int          e_sv;
    int          e_uv;
    logic        e_lock;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int fs0, err0, uv0, sv0, first, npulse;
    logic [23:0] rb;
    rb = 24'($urandom);

    vecs[0]  = '{10, -1, 24'h0ABCDE, 4'h5, 1, 0, 0, 0, 1'b0};  // sync from hunt
    vecs[1]  = '{10, -1, 24'h0ABCDE, 4'h5, 1, 0, 0, 0, 1'b0};  // good = 1
    vecs[2]  = '{10, -1, 24'h0ABCDE, 4'h5, 1, 0, 8, 1, 1'b1};  // good = 2 -> locked
    vecs[3]  = '{10, -1, 24'h000000, 4'h0, 1, 0, 8, 1, 1'b1};  // long zero data
    vecs[4]  = '{10, -1, rb, 4'(rb[3:0] ^ 4'hA), 1, 0, 8, 1, 1'b1};
    vecs[5]  = '{10, 13, 24'h0ABCDE, 4'h5, 1, 1, 2, 1, 1'b0};  // bad separator
    vecs[6]  = '{10, -1, 24'h0ABCDE, 4'h5, 1, 0, 0, 0, 1'b0};
    vecs[7]  = '{10, -1, 24'h0ABCDE, 4'h5, 1, 0, 0, 0, 1'b0};
    vecs[8]  = '{10, -1, 24'h0ABCDE, 4'h5, 1, 0, 8, 1, 1'b1};  // relocked
    vecs[9]  = '{9,  -1, 24'h0ABCDE, 4'h5, 0, 1, 0, 0, 1'b0};  // 9-zero sync
    vecs[10] = '{10, -1, 24'h0ABCDE, 4'h5, 1, 0, 0, 0, 1'b0};
    vecs[11] = '{11, -1, 24'h0ABCDE, 4'h5, 0, 1, 0, 0, 1'b0};  // 11th bit zero
    vecs[12] = '{12, -1, 24'h0ABCDE, 4'h5, 1, 0, 0, 0, 1'b0};  // long hunt run

    reset_n   = 1'b0;
    bit_valid = 1'b0;
    din       = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    check("rst_sample", 32'(sample), 32'h0);
    check("rst_channel", 32'(channel), 32'h0);
    check("rst_user", 32'(user), 32'h0);
    check("rst_pulses", {28'h0, sample_valid, user_valid, frame_start, sync_err}, 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    reset_n = 1'b1;

    for (int v = 0; v < 13; v++) begin
      fs0 = n_fs; err0 = n_err; uv0 = n_uv; sv0 = q_ch.size();
      send_sync(vecs[v].nz);
      send_groups(0, 48, vecs[v].badg, vecs[v].base, vecs[v].usr);
      check($sformatf("v%0d_fs", v), 32'(n_fs - fs0), 32'(vecs[v].e_fs));
      check($sformatf("v%0d_err", v), 32'(n_err - err0), 32'(vecs[v].e_err));
      check($sformatf("v%0d_nsv", v), 32'(q_ch.size() - sv0), 32'(vecs[v].e_sv));
      check($sformatf("v%0d_nuv", v), 32'(n_uv - uv0), 32'(vecs[v].e_uv));
      check($sformatf("v%0d_lock", v), 32'(locked), 32'(vecs[v].e_lock));
      if (vecs[v].e_uv > 0) check($sformatf("v%0d_user", v), 32'(last_user), 32'(vecs[v].usr));
      for (int i = sv0; i < q_ch.size() && i - sv0 < vecs[v].e_sv; i++) begin
        check($sformatf("v%0d_ch%0d", v, i - sv0), 32'(q_ch[i]), 32'(i - sv0));
        check($sformatf("v%0d_smp%0d", v, i - sv0), 32'(q_smp[i]),
              32'(chval(vecs[v].base, i - sv0)));
      end
    end

    // Watchdog: lock, then stop strobes after a single sync zero.
    for (int f = 0; f < 2; f++) begin
      send_sync(10);
      send_groups(0, 48, -1, 24'h0ABCDE, 4'h5);
    end
    check("wd_pre_lock", 32'(locked), 32'h1);
    @(posedge refclk); #1;
    bit_valid = 1'b1;
    din       = 1'b0;
    @(posedge refclk); #1;
    bit_valid = 1'b0;
    first  = -1;
    npulse = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge refclk); #1;
      if (sync_err) begin
        npulse++;
        if (first < 0) first = k;
      end
    end
    check("wd_delay", 32'(first), 32'(TO));
    check("wd_npulse", 32'(npulse), 32'h1);
    check("wd_lock", 32'(locked), 32'h0);

    // Mid-frame reset: relock, stop inside channel 3, reset asynchronously.
    send_sync(10);
    send_groups(0, 48, -1, 24'h0ABCDE, 4'h5);
    send_sync(10);
    send_groups(0, 48, -1, 24'h0ABCDE, 4'h5);
    send_sync(10);
    send_groups(0, 21, -1, 24'h0ABCDE, 4'h5);
    check("mr_pre_lock", 32'(locked), 32'h1);
    check("mr_pre_sample", 32'(sample), 32'(chval(24'h0ABCDE, 2)));
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_sample", 32'(sample), 32'h0);
    check("mr_chan_user", {25'h0, channel, user}, 32'h0);
    check("mr_lock", 32'(locked), 32'h0);
    @(posedge refclk); #1;
    reset_n = 1'b1;
    fs0 = n_fs; err0 = n_err;
    send_groups(22, 48, -1, 24'h0ABCDE, 4'h5);
    check("mr_no_fs", 32'(n_fs - fs0), 32'h0);
    check("mr_no_err", 32'(n_err - err0), 32'h0);
    send_sync(10);
    check("mr_fs_latency", 32'(fs_now), 32'h1);
    check("mr_fs_count", 32'(n_fs - fs0), 32'h1);
    send_groups(0, 48, -1, 24'h0ABCDE, 4'h5);
    send_sync(10);
    check("mr_lock_early", 32'(locked), 32'h0);
    send_groups(0, 48, -1, 24'h0ABCDE, 4'h5);
    send_sync(10);
    check("mr_relock", 32'(locked), 32'h1);
    check("mr_relock_fs", 32'(fs_now), 32'h1);

    repeat (4) @(posedge refclk);
    check("no_coincide", 32'(n_coinc), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
